mem_wb_stage: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline register.
- Takes the ALU result as the data address and dato_B as store data.
- Runs a req/ack transaction to data memory and stalls upstream while a transaction is outstanding.
- Registers the writeback value, destination register and write enable for the WB stage.

---
 rtl/mem_wb_stage.sv | 158 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM stage: issues req/ack data-memory transactions from EX/MEM and registers WB results.
// Optional misalignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_wb_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int RD_SEL_WIDTH   = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [31:0]             ALU_in,
  input  logic [31:0]             dato_B_in,
  input  logic [RD_SEL_WIDTH-1:0] rd_in,
  input  logic [RD_SEL_WIDTH-1:0] rt_in,
  input  logic                    reg_dst,
  input  logic                    reg_write,
  input  logic                    mem_read,
  input  logic                    mem_write,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [31:0]             dmem_addr,
  output logic [31:0]             dmem_wdata,
  input  logic [31:0]             dmem_rdata,
  input  logic                    dmem_ack,
  output logic                    stall_out,
  output logic [31:0]             wb_data,
  output logic [RD_SEL_WIDTH-1:0] wb_reg,
  output logic                    wb_we,
  output logic                    bus_err,
  output logic                    align_err
);

  // state | meaning
  // IDLE  | accepting instructions; ALU results pass straight to WB
  // WAIT  | memory request outstanding; upstream held until ack or timeout
  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                  state, state_d;
  logic [7:0]              cnt, cnt_d;
  logic                    req_d, we_d;
  logic [31:0]             addr_d, wdata_d, wb_data_d;
  logic [RD_SEL_WIDTH-1:0] wb_reg_d, lat_reg, lat_reg_d;
  logic                    wb_we_d, bus_err_d;
  logic                    lat_we, lat_we_d, lat_store, lat_store_d;
  logic                    mem_op, misalign;
  logic [RD_SEL_WIDTH-1:0] sel;

  assign mem_op = mem_read | mem_write;
  assign sel    = reg_dst ? rd_in : rt_in;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (ALU_in[1:0] != 2'b00);

  always_ff @(negedge clk) begin
    if (rst) align_err <= 1'b0;
    else     align_err <= (state == IDLE) & valid_in & mem_op & misalign;
  end
`else
  assign misalign  = 1'b0;
  assign align_err = 1'b0;
`endif

  assign stall_out = (state == WAIT) |
                     ((state == IDLE) & valid_in & mem_op & ~misalign & ~rst);

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    req_d       = dmem_req;
    we_d        = dmem_we;
    addr_d      = dmem_addr;
    wdata_d     = dmem_wdata;
    wb_data_d   = wb_data;
    wb_reg_d    = wb_reg;
    wb_we_d     = 1'b0;
    bus_err_d   = 1'b0;
    lat_reg_d   = lat_reg;
    lat_we_d    = lat_we;
    lat_store_d = lat_store;
    case (state)
      IDLE: begin
        if (valid_in && mem_op) begin
          if (!misalign) begin
            state_d     = WAIT;
            cnt_d       = 8'd0;
            req_d       = 1'b1;
            we_d        = mem_write;
            // Word-addressed memory: byte offset is never presented.
            addr_d      = {ALU_in[31:2], 2'b00};
            wdata_d     = dato_B_in;
            lat_reg_d   = sel;
            lat_we_d    = reg_write;
            lat_store_d = mem_write;
          end
        end else if (valid_in) begin
          wb_data_d = ALU_in;
          wb_reg_d  = sel;
          wb_we_d   = reg_write;
        end
      end
      WAIT: begin
        // Ack is checked first so a completion on the last allowed edge is not aborted.
        if (dmem_ack) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          req_d   = 1'b0;
          if (!lat_store) begin
            wb_data_d = dmem_rdata;
            wb_reg_d  = lat_reg;
            wb_we_d   = lat_we;
          end
        end else if (cnt == TC_LAST) begin
          state_d   = IDLE;
          cnt_d     = 8'd0;
          req_d     = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      wb_data    <= 32'd0;
      wb_reg     <= '0;
      wb_we      <= 1'b0;
      bus_err    <= 1'b0;
      lat_reg    <= '0;
      lat_we     <= 1'b0;
      lat_store  <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      dmem_req   <= req_d;
      dmem_we    <= we_d;
      dmem_addr  <= addr_d;
      dmem_wdata <= wdata_d;
      wb_data    <= wb_data_d;
      wb_reg     <= wb_reg_d;
      wb_we      <= wb_we_d;
      bus_err    <= bus_err_d;
      lat_reg    <= lat_reg_d;
      lat_we     <= lat_we_d;
      lat_store  <= lat_store_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: vector table for ALU pass-through, directed memory sequences,
// and randomized transactions checked against a transaction-level expectation model.
module tb_mem_wb_stage;
  localparam int TO = 4;

  logic        clk = 1'b1;
  logic        rst, valid_in, reg_dst, reg_write, mem_read, mem_write;
  logic [31:0] ALU_in, dato_B_in, dmem_rdata;
  logic [4:0]  rd_in, rt_in;
  logic        dmem_ack;
  logic        dmem_req, dmem_we, stall_out, wb_we, bus_err, align_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [4:0]  wb_reg;

  int n_tests = 0;
  int n_fail  = 0;

  mem_wb_stage #(.TIMEOUT_CYCLES(TO), .RD_SEL_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ALU_in(ALU_in), .dato_B_in(dato_B_in),
    .rd_in(rd_in), .rt_in(rt_in), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall_out(stall_out), .wb_data(wb_data), .wb_reg(wb_reg),
    .wb_we(wb_we), .bus_err(bus_err), .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Active edge is the falling edge; sample and drive 1 time unit after it.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_in();
    valid_in = 0; reg_dst = 0; reg_write = 0; mem_read = 0; mem_write = 0;
    ALU_in = 0; dato_B_in = 0; rd_in = 0; rt_in = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic set_in(input logic v, input logic mr, input logic mw, input logic rw,
                        input logic dst, input logic [4:0] rd, input logic [4:0] rt,
                        input logic [31:0] alu, input logic [31:0] b);
    valid_in = v; mem_read = mr; mem_write = mw; reg_write = rw; reg_dst = dst;
    rd_in = rd; rt_in = rt; ALU_in = alu; dato_B_in = b;
  endtask

  task automatic alu_op(input logic rw, input logic dst, input logic [4:0] rd,
                        input logic [4:0] rt, input logic [31:0] alu);
    set_in(1, 0, 0, rw, dst, rd, rt, alu, 32'h0);
    #1 chk("alu_stall_comb", stall_out, 0);
    tick();
    chk("alu_wb_we", wb_we, rw);
    if (rw) begin
      chk("alu_wb_reg", wb_reg, dst ? rd : rt);
      chk("alu_wb_data", wb_data, alu);
    end
    chk("alu_stall", stall_out, 0);
    chk("alu_req", dmem_req, 0);
    clr_in();
  endtask

  // d = WAIT edge (1-based) on which ack is presented; d > TO means no ack.
  task automatic mem_op(input logic mr, input logic mw, input logic rw, input logic dst,
                        input logic [4:0] rd, input logic [4:0] rt, input logic [31:0] alu,
                        input logic [31:0] b, input int d, input logic [31:0] rdata);
    logic is_store;
    int   stall_hi;
    logic misal;
    is_store = mw;
    stall_hi = 0;
`ifdef MEM_ALIGN_CHECK_EN
    misal = (alu % 4) != 0;
`else
    misal = 1'b0;
`endif
    set_in(1, mr, mw, rw, dst, rd, rt, alu, b);
    #1;
    if (misal) begin
      chk("mis_stall", stall_out, 0);
      tick();
      chk("mis_align_err", align_err, 1);
      chk("mis_req", dmem_req, 0);
      chk("mis_wb_we", wb_we, 0);
      clr_in();
      tick();
      chk("mis_align_pulse", align_err, 0);
      return;
    end
    chk("mem_stall_comb", stall_out, 1);
    if (stall_out) stall_hi++;
    tick();
    chk("mem_req", dmem_req, 1);
    chk("mem_we", dmem_we, is_store);
    chk("mem_addr", dmem_addr, alu - (alu % 4));
    chk("mem_wdata", dmem_wdata, b);
    chk("mem_wb_we_issue", wb_we, 0);
    for (int e = 1; e <= TO; e++) begin
      if (stall_out) stall_hi++;
      if (e == d) begin
        dmem_ack = 1; dmem_rdata = rdata;
      end
      tick();
      dmem_ack = 0;
      if (e == d) begin
        chk("done_req", dmem_req, 0);
        chk("done_bus_err", bus_err, 0);
        chk("done_wb_we", wb_we, !is_store && rw);
        if (!is_store && rw) begin
          chk("done_wb_reg", wb_reg, dst ? rd : rt);
          chk("done_wb_data", wb_data, rdata);
        end
        chk("done_stall_cycles", stall_hi, d + 1);
        clr_in();
        #1 chk("done_stall_release", stall_out, 0);
        return;
      end else if (e == TO) begin
        chk("to_req", dmem_req, 0);
        chk("to_bus_err", bus_err, 1);
        chk("to_wb_we", wb_we, 0);
        clr_in();
        #1 chk("to_stall_release", stall_out, 0);
        tick();
        chk("to_bus_err_pulse", bus_err, 0);
        return;
      end else begin
        chk("wait_req", dmem_req, 1);
        chk("wait_addr_hold", dmem_addr, alu - (alu % 4));
        chk("wait_wb_we", wb_we, 0);
      end
    end
  endtask

  typedef struct {
    logic        valid;
    logic        rw;
    logic        dst;
    logic [4:0]  rd;
    logic [4:0]  rt;
    logic [31:0] alu;
    logic        exp_we;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1, 1, 1, 5'd9,  5'd3,  32'h0000_00FF, 1, 5'd9,  32'h0000_00FF};
    vecs[1] = '{1, 1, 0, 5'd9,  5'd3,  32'hCAFE_0001, 1, 5'd3,  32'hCAFE_0001};
    vecs[2] = '{1, 0, 1, 5'd7,  5'd2,  32'h1111_2222, 0, 5'd0,  32'h0};
    vecs[3] = '{0, 1, 1, 5'd8,  5'd8,  32'h5555_AAAA, 0, 5'd0,  32'h0};
    vecs[4] = '{1, 1, 1, 5'd0,  5'd1,  32'hFFFF_FFFF, 1, 5'd0,  32'hFFFF_FFFF};
    vecs[5] = '{1, 1, 0, 5'd4,  5'd31, 32'h8000_0000, 1, 5'd31, 32'h8000_0000};

    clr_in();
    rst = 1;
    tick(); tick();
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_reg", wb_reg, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_align_err", align_err, 0);
    chk("rst_stall", stall_out, 0);
    rst = 0;

    foreach (vecs[i]) begin
      set_in(vecs[i].valid, 0, 0, vecs[i].rw, vecs[i].dst, vecs[i].rd, vecs[i].rt, vecs[i].alu, 0);
      #1 chk("vec_stall", stall_out, 0);
      tick();
      chk("vec_wb_we", wb_we, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        chk("vec_wb_reg", wb_reg, vecs[i].exp_reg);
        chk("vec_wb_data", wb_data, vecs[i].exp_data);
      end
    end
    clr_in();

    // Load with ack on third WAIT-side edge, store with ack on first.
    mem_op(1, 0, 1, 0, 5'd0, 5'd4, 32'h100, 32'h0, 3, 32'hDEAD_BEEF);
    mem_op(0, 1, 1, 1, 5'd6, 5'd0, 32'h204, 32'h1234_5678, 1, 32'h0);
    // Timeout, then ack exactly on the timeout edge.
    mem_op(1, 0, 1, 0, 5'd0, 5'd10, 32'h300, 32'h0, TO + 1, 32'h0);
    mem_op(1, 0, 1, 1, 5'd11, 5'd0, 32'h304, 32'h0, TO, 32'h0BAD_F00D);
    // Both read and write: behaves as a store.
    mem_op(1, 1, 1, 1, 5'd12, 5'd0, 32'h308, 32'hA5A5_A5A5, 2, 32'h7777_7777);
    // Misaligned load.
    mem_op(1, 0, 1, 0, 5'd0, 5'd4, 32'h102, 32'h0, 1, 32'h1357_9BDF);

    // Reset while waiting, then a stray ack.
    set_in(1, 1, 0, 1, 0, 5'd0, 5'd5, 32'h400, 32'h0);
    tick(); tick();
    chk("rw_req_before", dmem_req, 1);
    rst = 1;
    tick(); tick();
    chk("rw_req", dmem_req, 0);
    chk("rw_wb_we", wb_we, 0);
    chk("rw_stall", stall_out, 0);
    rst = 0;
    clr_in();
    dmem_ack = 1; dmem_rdata = 32'hFEED_FACE;
    tick();
    dmem_ack = 0;
    chk("rw_late_ack_we", wb_we, 0);
    chk("rw_late_ack_req", dmem_req, 0);
    chk("rw_late_ack_stall", stall_out, 0);

    for (int t = 0; t < 60; t++) begin
      int          kind;
      logic [31:0] alu;
      kind = $urandom_range(0, 3);
      alu  = $urandom;
      if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
      case (kind)
        0: alu_op(1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), alu);
        1: mem_op(1, 0, 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), alu,
                  $urandom, $urandom_range(1, TO + 1), $urandom);
        2: mem_op(1'($urandom), 1, 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
                  alu, $urandom, $urandom_range(1, TO + 1), $urandom);
        default: begin
          clr_in();
          dmem_ack = 1; dmem_rdata = $urandom;
          tick();
          dmem_ack = 0;
          chk("idle_ack_we", wb_we, 0);
          chk("idle_ack_req", dmem_req, 0);
          chk("idle_ack_err", bus_err, 0);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
